// File: rtl/clk_switch_sequencer.sv
// Purpose: arbitrates clock-source switch requests and sequences the glitch-free mux select (break -> make).
// Latency: a switch runs OFF_CYCLES+SETTLE_CYCLES+MIN_DWELL+2 cycles; no-op and reject replies arrive 1 cycle after arbitration.
// Backpressure: requests are level-held; they are only sampled in IDLE and stay pending while busy.
//
// Ports:
//   clk, rst_n          always-on control clock, synchronous active-low reset
//   req / req_idx       per-requester level request and target source index
//   src_ok              per-source "running" flag, already synchronised to clk
//   gnt / rej           one-cycle completion / refusal pulses per requester
//   clk_select          registered one-hot (or all-zero during break) mux select
//   cur_idx             index currently selected; busy is high outside IDLE
module clk_switch_sequencer #(
    parameter int NUM_CLOCKS    = 4,
    parameter int NUM_REQ       = 3,
    parameter int IDX_W         = 2,
    parameter int OFF_CYCLES    = 8,
    parameter int SETTLE_CYCLES = 8,
    parameter int MIN_DWELL     = 16,
    parameter int RESET_SEL     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    input  logic [NUM_CLOCKS-1:0]    src_ok,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rej,
    output logic [NUM_CLOCKS-1:0]    clk_select,
    output logic [IDX_W-1:0]         cur_idx,
    output logic                     busy
);

    localparam int MAX_OS = (OFF_CYCLES > SETTLE_CYCLES) ? OFF_CYCLES : SETTLE_CYCLES;
    localparam int MAX_C  = (MAX_OS > MIN_DWELL) ? MAX_OS : MIN_DWELL;
    localparam int CNT_W  = $clog2(MAX_C + 1);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NPAD   = 1 << IDX_W;

    localparam logic [CNT_W-1:0]      OFF_LOAD    = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DWELL_LOAD  = CNT_W'((MIN_DWELL > 0) ? MIN_DWELL - 1 : 0);
    localparam logic [NUM_CLOCKS-1:0] ONE_HOT0    = NUM_CLOCKS'(1);
    localparam logic [NUM_CLOCKS-1:0] RESET_VEC   = ONE_HOT0 << RESET_SEL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BREAK,
        S_MAKE,
        S_DONE,
        S_DWELL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] tgt_w;
    logic [IDX_W-1:0] tgt_idx;

    logic             win_vld;
    logic [PTR_W-1:0] win;
    logic [IDX_W-1:0] win_idx;
    logic             win_ok;
    logic [PTR_W-1:0] ptr_nxt;
    logic [NPAD-1:0]  src_ok_pad;

    // Indices beyond NUM_CLOCKS map onto zero-padded flags, so one lookup
    // covers both the range check and the source-running check.
    generate
        if (NPAD > NUM_CLOCKS) begin : g_pad
            assign src_ok_pad = {{(NPAD - NUM_CLOCKS){1'b0}}, src_ok};
        end else begin : g_nopad
            assign src_ok_pad = src_ok;
        end
    endgenerate

    // Round-robin search: first requester at or after rr_ptr.
    always_comb begin
        int r;
        win_vld = 1'b0;
        win     = '0;
        r       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            r = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_vld && req[r]) begin
                win_vld = 1'b1;
                win     = PTR_W'(r);
            end
        end
    end

    assign win_idx = req_idx[int'(win)*IDX_W +: IDX_W];
    assign win_ok  = src_ok_pad[win_idx];
    assign ptr_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rr_ptr     <= '0;
            tgt_w      <= '0;
            tgt_idx    <= '0;
            gnt        <= '0;
            rej        <= '0;
            busy       <= 1'b0;
            clk_select <= RESET_VEC;
            cur_idx    <= IDX_W'(RESET_SEL);
        end else begin
            gnt <= '0;
            rej <= '0;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        rr_ptr <= ptr_nxt;
                        if (!win_ok) begin
                            rej[win] <= 1'b1;
                        end else if (win_idx == cur_idx) begin
                            // Already on that source: acknowledge without a break.
                            gnt[win] <= 1'b1;
                        end else begin
                            tgt_w      <= win;
                            tgt_idx    <= win_idx;
                            clk_select <= '0;
                            cnt        <= OFF_LOAD;
                            busy       <= 1'b1;
                            state      <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (cnt == '0) begin
                        clk_select <= ONE_HOT0 << tgt_idx;
                        cur_idx    <= tgt_idx;
                        cnt        <= SETTLE_LOAD;
                        state      <= S_MAKE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_MAKE: begin
                    if (cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    gnt[tgt_w] <= 1'b1;
                    if (MIN_DWELL == 0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt   <= DWELL_LOAD;
                        state <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_sequencer.sv
// Purpose: self-checking bench for clk_switch_sequencer (table vectors, directed sequences, random vs reference model).
// Latency: checks outputs half a cycle after each rising edge.
// Backpressure: bench requesters hold req until the expected gnt/rej pulse.
module tb_clk_switch_sequencer;

    localparam int NC    = 4;
    localparam int NR    = 3;
    localparam int IW    = 2;
    localparam int OFF   = 8;
    localparam int SET   = 8;
    localparam int DW    = 16;
    localparam int RS    = 0;
    localparam int TOTAL = OFF + SET + DW + 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NR-1:0]  req = '0;
    logic [NR*IW-1:0] req_idx = '0;
    logic [NC-1:0]  src_ok = '1;
    logic [NR-1:0]  gnt, rej;
    logic [NC-1:0]  clk_select;
    logic [IW-1:0]  cur_idx;
    logic           busy;

    // Second instance with three sources to exercise an out-of-range index.
    logic [NR-1:0]    req3 = '0;
    logic [NR*IW-1:0] req_idx3 = '0;
    logic [2:0]       src_ok3 = 3'b111;
    logic [NR-1:0]    gnt3, rej3;
    logic [2:0]       clk_select3;
    logic [IW-1:0]    cur_idx3;
    logic             busy3;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk_on = 1'b0;

    always #5 clk = ~clk;

    clk_switch_sequencer #(
        .NUM_CLOCKS(NC), .NUM_REQ(NR), .IDX_W(IW), .OFF_CYCLES(OFF),
        .SETTLE_CYCLES(SET), .MIN_DWELL(DW), .RESET_SEL(RS)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_idx(req_idx), .src_ok(src_ok),
        .gnt(gnt), .rej(rej), .clk_select(clk_select), .cur_idx(cur_idx), .busy(busy)
    );

    clk_switch_sequencer #(
        .NUM_CLOCKS(3), .NUM_REQ(NR), .IDX_W(IW), .OFF_CYCLES(OFF),
        .SETTLE_CYCLES(SET), .MIN_DWELL(DW), .RESET_SEL(RS)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .req_idx(req_idx3), .src_ok(src_ok3),
        .gnt(gnt3), .rej(rej3), .clk_select(clk_select3), .cur_idx(cur_idx3), .busy(busy3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        req3  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Select must never carry more than one set bit.
    always @(negedge clk) begin
        if (chk_on) begin
            n_cmp++;
            if (!$onehot0(clk_select) || !$onehot0(clk_select3)) begin
                n_bad++;
                $display("FAIL onehot0: sel=%b sel3=%b", clk_select, clk_select3);
            end
        end
    end

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*IW-1:0] idx;
        logic [NC-1:0]    ok;
        logic [NR-1:0]    gnt;
        logic [NR-1:0]    rej;
        logic [NC-1:0]    sel;
        logic             busy;
    } vec_t;

    vec_t tbl[7];

    // Reference model state (timeline of one switch measured from its start edge).
    int          m_cur, m_ptr, m_d, m_w, m_idx;
    bit          m_sw;
    logic [NR-1:0] e_gnt, e_rej;
    logic [NC-1:0] e_sel;
    logic [NC-1:0] one4;

    task automatic model_edge();
        int w;
        int ti;
        e_gnt = '0;
        e_rej = '0;
        if (m_sw) begin
            m_d++;
            if (m_d == OFF) m_cur = m_idx;
            if (m_d == OFF + SET + 1) e_gnt[m_w] = 1'b1;
            if (m_d == TOTAL - 1) m_sw = 1'b0;
        end else if (req != '0) begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            end
            m_ptr = (w + 1) % NR;
            ti = int'(req_idx[w*IW +: IW]);
            if (ti >= NC || !src_ok[ti]) e_rej[w] = 1'b1;
            else if (ti == m_cur) e_gnt[w] = 1'b1;
            else begin
                m_sw  = 1'b1;
                m_d   = 0;
                m_w   = w;
                m_idx = ti;
            end
        end
        if (!m_sw) e_sel = one4 << m_cur;
        else if (m_d < OFF) e_sel = '0;
        else e_sel = one4 << m_idx;
    endtask

    initial begin
        int gt[3];
        int ord[$];
        int cyc;
        bit seen;
        one4 = 4'b0001;

        tbl[0] = '{3'b001, 6'b00_00_00, 4'b1111, 3'b001, 3'b000, 4'b0001, 1'b0};
        tbl[1] = '{3'b010, 6'b00_10_00, 4'b1011, 3'b000, 3'b010, 4'b0001, 1'b0};
        tbl[2] = '{3'b100, 6'b11_00_00, 4'b0111, 3'b000, 3'b100, 4'b0001, 1'b0};
        tbl[3] = '{3'b011, 6'b00_00_01, 4'b1111, 3'b000, 3'b000, 4'b0000, 1'b1};
        tbl[4] = '{3'b110, 6'b00_00_00, 4'b1111, 3'b010, 3'b000, 4'b0001, 1'b0};
        tbl[5] = '{3'b100, 6'b00_00_00, 4'b1110, 3'b000, 3'b100, 4'b0001, 1'b0};
        tbl[6] = '{3'b101, 6'b01_00_11, 4'b1111, 3'b000, 3'b000, 4'b0000, 1'b1};

        // Reset state held for 10 cycles.
        do_reset();
        chk_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("rst_sel", clk_select, 4'b0001);
            chk("rst_cur", cur_idx, 0);
            chk("rst_busy", busy, 0);
            tick();
        end

        // Single-arbitration vectors from a fresh reset.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            src_ok  = tbl[i].ok;
            req_idx = tbl[i].idx;
            req     = tbl[i].req;
            tick();
            chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("vec%0d_rej", i), rej, tbl[i].rej);
            chk($sformatf("vec%0d_sel", i), clk_select, tbl[i].sel);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            req = '0;
        end
        src_ok = '1;

        // Full switch 0 -> 2 timeline.
        do_reset();
        req_idx = 6'b00_00_10;
        req     = 3'b001;
        tick();
        chk("sw_break0_sel", clk_select, 4'b0000);
        chk("sw_break0_busy", busy, 1);
        ticks(OFF - 1);
        chk("sw_break_end_sel", clk_select, 4'b0000);
        tick();
        chk("sw_make_sel", clk_select, 4'b0100);
        chk("sw_make_cur", cur_idx, 2);
        ticks(SET);
        chk("sw_pre_gnt", gnt, 3'b000);
        tick();
        chk("sw_gnt", gnt, 3'b001);
        req = '0;
        tick();
        chk("sw_gnt_once", gnt, 3'b000);
        chk("sw_dwell_busy", busy, 1);
        ticks(14);
        chk("sw_dwell_last_busy", busy, 1);
        tick();
        chk("sw_idle_busy", busy, 0);
        chk("sw_idle_sel", clk_select, 4'b0100);

        // Request for the already-selected source.
        req_idx = 6'b00_10_00;
        req     = 3'b010;
        tick();
        chk("noop_gnt", gnt, 3'b010);
        chk("noop_busy", busy, 0);
        chk("noop_sel", clk_select, 4'b0100);
        req = '0;
        tick();
        chk("noop_gnt_once", gnt, 3'b000);
        chk("noop_sel2", clk_select, 4'b0100);

        // All three requesters at once: served 0,1,2 one full switch apart.
        do_reset();
        req_idx = 6'b11_10_01;
        req     = 3'b111;
        gt[0] = -1; gt[1] = -1; gt[2] = -1;
        ord.delete();
        for (int c = 1; c <= 4 * TOTAL && req != '0; c++) begin
            tick();
            for (int r = 0; r < NR; r++) begin
                if (gnt[r]) begin
                    gt[r] = c;
                    req[r] = 1'b0;
                    ord.push_back(r);
                end
            end
        end
        chk("rr_pending", req, 0);
        chk("rr_count", ord.size(), 3);
        if (ord.size() == 3) begin
            chk("rr_order0", ord[0], 0);
            chk("rr_order1", ord[1], 1);
            chk("rr_order2", ord[2], 2);
        end
        chk("rr_t0", gt[0], OFF + SET + 2);
        chk("rr_t1", gt[1], OFF + SET + 2 + TOTAL);
        chk("rr_t2", gt[2], OFF + SET + 2 + 2 * TOTAL);
        chk("rr_final_sel", clk_select, 4'b1000);
        req = '0;

        // Reset in the middle of a break, then a normal switch.
        do_reset();
        req_idx = 6'b00_00_11;
        req     = 3'b001;
        ticks(4);
        chk("abort_mid_sel", clk_select, 4'b0000);
        rst_n = 1'b0;
        req   = '0;
        tick();
        chk("abort_sel", clk_select, 4'b0001);
        chk("abort_cur", cur_idx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_gnt", gnt, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt != '0) seen = 1'b1;
        end
        chk("abort_no_gnt", seen, 0);
        req_idx = 6'b01_00_00;
        req     = 3'b100;
        cyc = -1;
        for (int c = 1; c <= 3 * TOTAL && cyc < 0; c++) begin
            tick();
            if (gnt != '0) begin
                cyc = c;
                chk("after_abort_gnt", gnt, 3'b100);
                req = '0;
            end
        end
        chk("after_abort_t", cyc, OFF + SET + 2);
        chk("after_abort_sel", clk_select, 4'b0010);

        // Three-source instance: index 3 is out of range.
        do_reset();
        req_idx3 = 6'b00_00_11;
        req3     = 3'b001;
        tick();
        chk("nc3_rej", rej3, 3'b001);
        chk("nc3_gnt", gnt3, 3'b000);
        chk("nc3_sel", clk_select3, 3'b001);
        chk("nc3_busy", busy3, 0);
        req3 = '0;

        // Random traffic against the reference model.
        do_reset();
        m_cur = RS; m_ptr = 0; m_sw = 1'b0; m_d = 0; m_w = 0; m_idx = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)
                src_ok = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            if (m_sw && $urandom_range(0, 15) == 0) req[m_w] = 1'b0;
            for (int r = 0; r < NR; r++) begin
                if (!req[r] && !(m_sw && r == m_w) && $urandom_range(0, 3) == 0) begin
                    req_idx[r*IW +: IW] = IW'($urandom_range(0, 3));
                    req[r] = 1'b1;
                end
            end
            model_edge();
            tick();
            chk("rnd_gnt", gnt, e_gnt);
            chk("rnd_rej", rej, e_rej);
            chk("rnd_sel", clk_select, e_sel);
            chk("rnd_cur", cur_idx, m_cur);
            chk("rnd_busy", busy, m_sw);
            req = req & ~(e_gnt | e_rej);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
